// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared constants for the serial transmitter and a matching receiver:
//   - FSM state encodings (3-bit, plain localparams so older tools and
//     hand-written decoders can compare against them directly)
//   - line-level constants (idle/stop level and start-bit level)
// -----------------------------------------------------------------------------
package piso_pkg;

   localparam int ST_W = 3;

   localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [ST_W-1:0] ST_START  = 3'd1;
   localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
   localparam logic [ST_W-1:0] ST_PARITY = 3'd3;
   localparam logic [ST_W-1:0] ST_STOP   = 3'd4;

   // Line rests high between frames; the stop bit uses the same level.
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/dff.sv
// -----------------------------------------------------------------------------
// dff
// Basic W-bit register cell with synchronous, active-high reset.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous reset, loads RST_VAL
//   d    - next value
//   q    - registered value
// -----------------------------------------------------------------------------
module dff #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) q <= RST_VAL;
      else     q <= d;
   end

endmodule

// File: rtl/shift_reg_ld.sv
// -----------------------------------------------------------------------------
// shift_reg_ld
// Parallel-load shift register. The bit about to be transmitted is always
// presented on 'head'; each shift moves the next bit into the head position
// and fills the vacated end with zero.
// Parameters:
//   WIDTH     - register width (>= 2)
//   LSB_FIRST - 1: head is bit 0, shifts right; 0: head is bit WIDTH-1,
//               shifts left
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous reset, clears the register
//   load  - capture din (has priority over shift)
//   shift - advance by one bit
//   din   - parallel word
//   head  - current output bit
// -----------------------------------------------------------------------------
module shift_reg_ld #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             head
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = din;
      end else if (shift) begin
         if (LSB_FIRST) data_d = {1'b0, data_q[WIDTH-1:1]};
         else           data_d = {data_q[WIDTH-2:0], 1'b0};
      end
   end

   dff #(
      .W       (WIDTH),
      .RST_VAL ('0)
   ) u_data (
      .clk (clk),
      .rst (rst),
      .d   (data_d),
      .q   (data_q)
   );

   assign head = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];

endmodule

// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx
// Parallel-in serial-out transmitter. A word accepted on load_valid &&
// load_ready is sent as: one start bit (0), WIDTH data bits, an optional
// even-parity bit, and one stop bit (1). The line idles high.
//
// Build option:
//   PISO_TX_PARITY_EN - when defined, a parity bit (XOR of the captured word)
//                       is sent between the last data bit and the stop bit.
//
// Parameters:
//   WIDTH     - data word width, 2..32
//   LSB_FIRST - 1: bit 0 sent first; 0: bit WIDTH-1 sent first
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous, active-high reset; aborts any frame in flight
//   din        - word to transmit (sampled only when accepted)
//   load_valid - din valid this cycle
//   load_ready - high only while idle (decoded from state)
//   sout       - registered serial line
//   busy       - registered, high for every cycle of a frame
//   done       - registered, one-cycle pulse during the stop bit
// -----------------------------------------------------------------------------
module piso_tx
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam int               CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [ST_W-1:0]  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sout_q, sout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             sr_load;
   logic             sr_shift;
   logic             sr_head;

`ifdef PISO_TX_PARITY_EN
   // Parity is taken from din at capture time, so it never depends on how
   // far the shift register has advanced.
   logic             par_q, par_d;
`endif

   // Next-state and control. Registered outputs are derived from state_d so
   // that each output is valid in the same cycle the FSM enters a state.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_d    = par_q;
`endif

      case (state_q)
         ST_IDLE: begin
            // load_ready is 1 in IDLE, so load_valid alone means accept.
            if (load_valid) begin
               state_d = ST_START;
               sr_load = 1'b1;
`ifdef PISO_TX_PARITY_EN
               par_d   = ^din;
`endif
            end
         end

         ST_START: begin
            // Head already holds the first data bit; present it and advance.
            state_d  = ST_DATA;
            cnt_d    = '0;
            sr_shift = 1'b1;
         end

         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
`ifdef PISO_TX_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
`endif
               cnt_d   = '0;
            end else begin
               cnt_d    = cnt_q + 1'b1;
               sr_shift = 1'b1;
            end
         end

`ifdef PISO_TX_PARITY_EN
         ST_PARITY: begin
            state_d = ST_STOP;
         end
`endif

         ST_STOP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Line level for the cycle that follows this edge.
   always_comb begin
      sout_d = LINE_IDLE;
      case (state_d)
         ST_START:  sout_d = START_BIT;
         ST_DATA:   sout_d = sr_head;
`ifdef PISO_TX_PARITY_EN
         ST_PARITY: sout_d = par_q;
`endif
         default:   sout_d = LINE_IDLE;
      endcase
   end

   assign busy_d = (state_d != ST_IDLE);
   assign done_d = (state_d == ST_STOP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sout_q  <= LINE_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sout_q  <= sout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef PISO_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= par_d;
   end
`endif

   shift_reg_ld #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
   ) u_shift (
      .clk   (clk),
      .rst   (rst),
      .load  (sr_load),
      .shift (sr_shift),
      .din   (din),
      .head  (sr_head)
   );

   assign load_ready = (state_q == ST_IDLE);
   assign sout       = sout_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits (legal range 2..32).
REQ-002 Parameter: LSB_FIRST, 1, 1 sends bit 0 first; 0 sends bit WIDTH-1 first.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: din  input  WIDTH  parallel word to transmit.
REQ-006 Port: load_valid  input  1  din is valid this cycle.
REQ-007 Port: load_ready  output  1  block can accept a word this cycle.
REQ-008 Port: sout  output  1  serial line, registered, idle-high.
REQ-009 Port: busy  output  1  frame in progress.
REQ-010 Port: done  output  1  one-cycle pulse during the stop-bit cycle.

Function
REQ-011 The block SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 Accept: load_valid && load_ready at edge N SHALL capture din into the shift register and enter START.
REQ-013 load_ready SHALL be 1 only in IDLE; load_valid outside IDLE SHALL be ignored and din SHALL NOT be sampled.
REQ-014 sout SHALL be 0 for exactly one cycle in START, starting at cycle N+1.
REQ-015 DATA SHALL last WIDTH cycles, one bit per cycle, in the order given by LSB_FIRST.
REQ-016 The bit counter SHALL be $clog2(WIDTH)+1 bits wide, count 0..WIDTH-1, and leave DATA when it reaches WIDTH-1, with no wrap.
REQ-017 STOP SHALL drive sout=1 for one cycle, assert done, and return to IDLE.
REQ-018 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-019 Frame length SHALL be WIDTH+2 cycles, or WIDTH+3 with parity.
REQ-020 Back-to-back: load_ready SHALL rise on the cycle after STOP; the minimum gap between frames is one idle-high cycle.
REQ-021 sout, busy and done SHALL be registered outputs; load_ready SHALL be decoded from state only.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, sout=1, busy=0, done=0, load_ready=1, counter=0 and shift register=0.
REQ-023 rst mid-frame SHALL abort the frame immediately, with no stop bit and no done pulse.
REQ-024 rst and load_valid in the same cycle: reset SHALL win and the word SHALL be dropped.

Configuration
REQ-025 Macro PISO_TX_PARITY_EN defined: PARITY state SHALL follow DATA and drive sout = XOR of the captured word (even parity) for one cycle.
REQ-026 Macro PISO_TX_PARITY_EN undefined: PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-027 State encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) and the line-idle constant SHALL live in the shared package piso_pkg, for reuse by a matching receiver.
REQ-028 The shift register SHALL be a sub-module shift_reg_ld (parallel load, shift enable, direction parameter, synchronous rst) built on the team's dff cell.

Verification
REQ-029 Reset: hold rst 2 cycles -> sout=1, busy=0, done=0, load_ready=1.
REQ-030 WIDTH=8, LSB_FIRST=1, din=8'hA5 accepted -> sout sequence 0,1,0,1,0,0,1,0,1,1 and done high on the tenth cycle.
REQ-031 LSB_FIRST=0, din=8'h81 -> sout sequence 0,1,0,0,0,0,0,0,1,1.
REQ-032 PISO_TX_PARITY_EN, din=8'h07 -> parity bit 1 after data; frame is 11 cycles.
REQ-033 Assert rst at data bit 3 of 8'hFF -> next cycle sout=1 and busy=0, with no done pulse ever.
REQ-034 Hold load_valid high with 8'h3C then 8'hC3 -> second word captured only at IDLE, with exactly one idle-high cycle between frames.
